// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine sharing one shifter and adder; owns the HI/LO result registers.
// Optional build macro MULDIV_EARLY_EXIT_EN enables early termination of multiplies.
module muldiv_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    // Command handshake: start is taken only in IDLE and not during the done cycle;
    // busy covers the whole operation and done (with div0 on a zero divisor) pulses once at the end.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d, done_q, done_d, div0_q, div0_d;

    logic               is_div, is_sgn, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     add_x, add_y;
    logic               add_cin;
    logic [WIDTH+1:0]   add_s;
    logic               early;

    assign is_div = op_q[1];
    assign is_sgn = ~op_q[0];
    assign a_neg  = is_sgn & a_q[WIDTH-1];
    assign b_neg  = is_sgn & b_q[WIDTH-1];
    assign a_mag  = a_neg ? -a_q : a_q;
    assign b_mag  = b_neg ? -b_q : b_q;

    // Multiply adds the multiplicand to the upper half; divide subtracts the divisor from the shifted remainder.
    always_comb begin
        if (is_div) begin
            add_x   = acc_q[2*WIDTH-1:WIDTH-1];
            add_y   = ~{1'b0, b_q};
            add_cin = 1'b1;
        end else begin
            add_x   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
            add_y   = {1'b0, a_q};
            add_cin = 1'b0;
        end
        add_s = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};
    end

`ifdef MULDIV_EARLY_EXIT_EN
    logic [CNT_W-1:0] skip_sh;
    logic [WIDTH-1:0] low_mask;
    // The low cnt_q bits of the lower half are the multiplier bits still to be consumed.
    assign skip_sh  = CNT_W'(WIDTH) - cnt_q;
    assign low_mask = {WIDTH{1'b1}} >> skip_sh;
    assign early    = ~is_div & ((acc_q[WIDTH-1:0] & low_mask) == '0);
`else
    assign early    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        zero_d   = zero_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        div0_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !done_q) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    zero_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                a_d      = a_mag;
                b_d      = b_mag;
                neg_lo_d = a_neg ^ b_neg;
                neg_hi_d = is_div ? a_neg : (a_neg ^ b_neg);
                acc_d    = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                if (is_div && b_q == '0) begin
                    zero_d  = 1'b1;
                    state_d = S_FIX;
                end else begin
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (early) begin
                    acc_d   = acc_q >> cnt_q;
                    cnt_d   = '0;
                    state_d = S_FIX;
                end else begin
                    if (is_div) begin
                        // A carry out means the trial remainder did not go negative.
                        if (add_s[WIDTH+1]) begin
                            acc_d = {add_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = {(acc_q[0] ? add_s[WIDTH:0] : {1'b0, acc_q[2*WIDTH-1:WIDTH]}),
                                 acc_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (zero_q) begin
                    div0_d = 1'b1;
                end else if (is_div) begin
                    lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    {hi_d, lo_d} = neg_lo_q ? -acc_q : acc_q;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_q    <= acc_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign div0      = div0_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, hand sequences for the corner cases, random ops vs a 64-bit arithmetic model.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div0;
    logic [W-1:0] hi, lo;
    logic [1:0]   dbg_state;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         div0;
    } vec_t;

    vec_t tbl[15];

    muldiv_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected edges from the start-sampling edge to the edge that raises done.
    function automatic int lat_of(input logic [1:0] o, input logic [W-1:0] bv);
`ifdef MULDIV_EARLY_EXIT_EN
        logic [W-1:0] mag;
        int msb;
`endif
        if (o[1] && bv == '0) return 2;
`ifdef MULDIV_EARLY_EXIT_EN
        if (!o[1]) begin
            mag = (o == 2'b00 && bv[W-1]) ? -bv : bv;
            if (mag == '0) return 3;
            msb = 0;
            for (int i = 0; i < W; i++) if (mag[i]) msb = i;
            return (msb + 4 < W + 2) ? msb + 4 : W + 2;
        end
`endif
        return W + 2;
    endfunction

    function automatic void ref_calc(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                     output logic [W-1:0] r_hi, output logic [W-1:0] r_lo,
                                     output logic r_div0);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        r_hi = m_hi;
        r_lo = m_lo;
        r_div0 = 1'b0;
        case (o)
            2'd0: begin p = sa * sb; r_hi = p[63:32]; r_lo = p[31:0]; end
            2'd1: begin p = {32'b0, av} * {32'b0, bv}; r_hi = p[63:32]; r_lo = p[31:0]; end
            2'd2: begin
                if (bv == '0) r_div0 = 1'b1;
                else begin
                    p = sa / sb; r_lo = p[31:0];
                    p = sa % sb; r_hi = p[31:0];
                end
            end
            default: begin
                if (bv == '0) r_div0 = 1'b1;
                else begin r_lo = av / bv; r_hi = av % bv; end
            end
        endcase
    endfunction

    // Entered #1 after the edge that accepted the command.
    task automatic wait_done(input string name, input int e_lat, input logic e_div0);
        int n;
        bit found;
        logic [W-1:0] eh, el;
        n = 0;
        found = 0;
        while (!found && n < 200) begin
            @(posedge clock); #1;
            n++;
            if (done) found = 1;
        end
        eh = exp_q.pop_front();
        el = exp_q.pop_front();
        chk({name, " done seen"}, found, 1);
        if (found) begin
            chk({name, " latency"}, n, e_lat);
            chk({name, " div0"}, div0, e_div0);
            chk({name, " busy at done"}, busy, 0);
            chk({name, " hi"}, hi, eh);
            chk({name, " lo"}, lo, el);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] e_hi, input logic [W-1:0] e_lo, input logic e_div0);
        @(posedge clock); #1;
        exp_q.push_back(e_hi);
        exp_q.push_back(e_lo);
        op = o; a = av; b = bv; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
        chk({name, " busy after accept"}, busy, 1);
        wait_done(name, lat_of(o, bv), e_div0);
        m_hi = e_hi;
        m_lo = e_lo;
    endtask

    initial begin
        logic [W-1:0] r_hi, r_lo;
        logic r_div0;
        logic [1:0] ro;
        logic [W-1:0] ra, rb;
        int dones;

        tbl[0]  = '{2'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        tbl[1]  = '{2'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0};
        tbl[2]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3]  = '{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0};
        tbl[4]  = '{2'd1, 32'h80000001, 32'h00000002, 32'h00000001, 32'h00000002, 1'b0};
        tbl[5]  = '{2'd2, 32'h00000005, 32'h00000000, 32'h00000001, 32'h00000002, 1'b1};
        tbl[6]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[7]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[8]  = '{2'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
        tbl[9]  = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        tbl[10] = '{2'd3, 32'h00000005, 32'h00000000, 32'h00000001, 32'hFFFFFFFD, 1'b1};
        tbl[11] = '{2'd0, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0};
        tbl[12] = '{2'd3, 32'h00000003, 32'h00000007, 32'h00000003, 32'h00000000, 1'b0};
        tbl[13] = '{2'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0};
        tbl[14] = '{2'd1, 32'h00000009, 32'h00000003, 32'h00000000, 32'h0000001B, 1'b0};

        reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset div0", div0, 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        chk("reset state", dbg_state, 0);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].div0);
        end

        // start in the done cycle is dropped, then taken one cycle later
        start = 1'b1; op = 2'd1; a = 32'd5; b = 32'd5;
        @(posedge clock); #1;
        chk("start at done ignored", busy, 0);
        @(posedge clock); #1;
        start = 1'b0;
        chk("start after done taken", busy, 1);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd25);
        wait_done("late start", lat_of(2'd1, 32'd5), 1'b0);
        m_hi = 32'd0; m_lo = 32'd25;

        // second start during RUN is neither queued nor disturbs the running op
        @(posedge clock); #1;
        op = 2'd0; a = 32'd6; b = 32'd7; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd42);
        repeat (2) @(posedge clock);
        #1;
        start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        chk("busy during run", busy, 1);
        wait_done("start while busy", lat_of(2'd0, 32'd7) - 3, 1'b0);
        m_hi = 32'd0; m_lo = 32'd42;
        dones = 0;
        repeat (45) begin
            @(posedge clock); #1;
            if (done) dones++;
        end
        chk("no queued op", dones, 0);

        // reset in the middle of RUN
        op = 2'd0; a = 32'd123; b = 32'hFFFF0001; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort hi", hi, 0);
        chk("abort lo", lo, 0);
        chk("abort state", dbg_state, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        dones = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) dones++;
        end
        chk("no done after abort", dones, 0);
        run_op("mult after abort", 2'd0, 32'd6, 32'd7, 32'd0, 32'h2A, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 4))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            ref_calc(ro, ra, rb, r_hi, r_lo, r_div0);
            run_op($sformatf("rand%0d", i), ro, ra, rb, r_hi, r_lo, r_div0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
